cordic_vector_iter: RTL and testbench

- Iterative vectoring-mode CORDIC; the inverse of the pipelined rotation cells.
- Takes a Cartesian vector (x,y), drives y to zero and reports the gain-compensated magnitude and the angle atan2(y,x).
- Uses one shared micro-rotation datapath over ITERATIONS cycles, with valid/ready handshakes on both sides.
- Sits after the rotation pipeline (demod/phase-detect path) to recover amplitude and phase.

---
 rtl/cordic_pkg.sv | 41 ++++
 rtl/cordic_vec_step.sv | 38 +++
 rtl/cordic_vector_iter.sv | 159 +++++++++++++++
 tb/tb_cordic_vector_iter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, types and helpers for the vectoring CORDIC.
package cordic_pkg;

    localparam int ANG_W          = 16;
    localparam int XY_W           = 18;
    localparam int CNT_W          = 4;
    localparam int ATAN_N         = 16;
    localparam int INV_GAIN_SHIFT = 15;
    localparam int PROD_W         = XY_W + INV_GAIN_SHIFT;

    // round(atan(2^-i) * 32768 / pi), angle LSB = pi/32768
    localparam logic [ANG_W-1:0] ATAN_TBL [0:ATAN_N-1] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297,
        16'd651,  16'd326,  16'd163,  16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,
        16'd3,    16'd1,    16'd1,    16'd0
    };

    // 1/K in Q0.15
    localparam logic [INV_GAIN_SHIFT-1:0] CORDIC_INV_GAIN = 15'd19898;

    localparam logic [ANG_W-1:0] ANG_PI_HALF_POS = 16'd16384;
    localparam logic [ANG_W-1:0] ANG_PI_HALF_NEG = 16'hC000;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        COMP,
        DONE
    } state_t;

    // Gain compensation: (x * 1/K) >> 15, x non-negative, saturated to 16 bits.
    function automatic logic [ANG_W-1:0] scale_mag(input logic [XY_W-1:0] x);
        logic [PROD_W-1:0] prod;
        logic [PROD_W-1:0] scaled;
        prod   = PROD_W'(x) * PROD_W'(CORDIC_INV_GAIN);
        scaled = prod >> INV_GAIN_SHIFT;
        return (|scaled[PROD_W-1:ANG_W]) ? '1 : scaled[ANG_W-1:0];
    endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// One combinational vectoring micro-rotation: steers y toward zero and
// accumulates the applied angle into z.
module cordic_vec_step
    import cordic_pkg::*;
(
    input  logic signed [XY_W-1:0]  i_x,
    input  logic signed [XY_W-1:0]  i_y,
    input  logic        [ANG_W-1:0] i_z,
    input  logic        [CNT_W-1:0] i_shift,
    input  logic        [ANG_W-1:0] i_atan,
    output logic signed [XY_W-1:0]  o_x,
    output logic signed [XY_W-1:0]  o_y,
    output logic        [ANG_W-1:0] o_z
);

    logic signed [XY_W-1:0] w_x_sh;
    logic signed [XY_W-1:0] w_y_sh;

    assign w_x_sh = i_x >>> i_shift;
    assign w_y_sh = i_y >>> i_shift;

    // Rotate against the sign of y using pre-update x/y; z wraps modulo 2^16.
    always_comb begin
        o_x = i_x;
        o_y = i_y;
        o_z = i_z;
        if (!i_y[XY_W-1]) begin
            o_x = i_x + w_y_sh;
            o_y = i_y - w_x_sh;
            o_z = i_z + i_atan;
        end else begin
            o_x = i_x - w_y_sh;
            o_y = i_y + w_x_sh;
            o_z = i_z - i_atan;
        end
    end

endmodule

// File: rtl/cordic_vector_iter.sv
// Iterative vectoring-mode CORDIC: converts (x,y) to gain-compensated
// magnitude and atan2(y,x) using one shared micro-rotation per cycle.
module cordic_vector_iter
    import cordic_pkg::*;
#(
    parameter int ITERATIONS = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic        [15:0] mag_out,
    output logic signed [15:0] ang_out
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_accept;

    logic signed [XY_W-1:0] r_x;
    logic signed [XY_W-1:0] r_y;
    logic [ANG_W-1:0]       r_z;
    logic [CNT_W-1:0]       r_iter;
    logic                   r_zero;
    logic [ANG_W-1:0]       r_mag;
    logic [ANG_W-1:0]       r_ang;

    logic signed [XY_W-1:0] w_x_ext;
    logic signed [XY_W-1:0] w_y_ext;
    logic signed [XY_W-1:0] w_x_ld;
    logic signed [XY_W-1:0] w_y_ld;
    logic [ANG_W-1:0]       w_z_ld;
    logic signed [XY_W-1:0] w_x_step;
    logic signed [XY_W-1:0] w_y_step;
    logic [ANG_W-1:0]       w_z_step;

    assign w_x_ext = XY_W'(x_in);
    assign w_y_ext = XY_W'(y_in);

    assign mag_out = r_mag;
    assign ang_out = r_ang;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ITER;
                end
            end
            ITER: begin
                if (r_iter == LAST_ITER) begin
                    w_state_nxt = COMP;
                end
            end
            COMP: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Pre-rotation by +/-90 degrees folds left-half-plane inputs into x>=0.
    always_comb begin
        w_x_ld = w_x_ext;
        w_y_ld = w_y_ext;
        w_z_ld = '0;
        if (x_in[15]) begin
            if (!y_in[15]) begin
                w_x_ld = w_y_ext;
                w_y_ld = -w_x_ext;
                w_z_ld = ANG_PI_HALF_POS;
            end else begin
                w_x_ld = -w_y_ext;
                w_y_ld = w_x_ext;
                w_z_ld = ANG_PI_HALF_NEG;
            end
        end
    end

    cordic_vec_step u_step (
        .i_x     (r_x),
        .i_y     (r_y),
        .i_z     (r_z),
        .i_shift (r_iter),
        .i_atan  (ATAN_TBL[r_iter]),
        .o_x     (w_x_step),
        .o_y     (w_y_step),
        .o_z     (w_z_step)
    );

    // Datapath: load on accept, iterate, then gain-compensate into the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_iter <= '0;
            r_zero <= 1'b0;
            r_mag  <= '0;
            r_ang  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x    <= w_x_ld;
                        r_y    <= w_y_ld;
                        r_z    <= w_z_ld;
                        r_iter <= '0;
                        r_zero <= (x_in == 16'sd0) && (y_in == 16'sd0);
                    end
                end
                ITER: begin
                    r_x    <= w_x_step;
                    r_y    <= w_y_step;
                    r_z    <= w_z_step;
                    r_iter <= r_iter + 1'b1;
                end
                COMP: begin
                    // A (0,0) input still accumulates angle; report zero instead.
                    r_mag <= r_zero ? '0 : scale_mag(r_x);
                    r_ang <= r_zero ? '0 : r_z;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vector_iter.sv
// Self-checking bench for cordic_vector_iter against a real-arithmetic
// magnitude/atan2 reference.
module tb_cordic_vector_iter;

    localparam int  ITERS  = 14;
    localparam real PI     = 3.14159265358979323846;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic               out_valid;
    logic               out_ready;
    logic        [15:0] mag_out;
    logic signed [15:0] ang_out;

    int total = 0;
    int bad   = 0;

    cordic_vector_iter #(.ITERATIONS(ITERS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .ang_out   (ang_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference angle in LSBs of pi/32768, rounded to nearest.
    function automatic int ref_ang(input int vx, input int vy);
        return int'($atan2(real'(vy), real'(vx)) * 32768.0 / PI);
    endfunction

    function automatic real ref_mag(input int vx, input int vy);
        return $sqrt(real'(vx) * real'(vx) + real'(vy) * real'(vy));
    endfunction

    task automatic check_result(input string tag, input int vx, input int vy, input int atol);
        real tm;
        real mtol;
        real md;
        int  ta;
        int  d;
        bit  ok;
        if (vx == 0 && vy == 0) begin
            check_eq({tag, "_mag0"}, 32'(mag_out), 0);
            check_eq({tag, "_ang0"}, 32'(ang_out), 0);
        end else begin
            tm   = ref_mag(vx, vy);
            mtol = tm * 0.001 + 2.0;
            md   = real'(mag_out) - tm;
            ok   = (md <= mtol) && (md >= -mtol);
            total++;
            assert (ok === 1'b1) else begin
                bad++;
                $error("FAIL %s_mag observed=%0d expected=%0d+-%0d", tag, mag_out,
                       int'(tm), int'(mtol));
            end
            ta = ref_ang(vx, vy);
            d  = int'(ang_out) - ta;
            d  = ((d % 65536) + 65536 + 32768) % 65536 - 32768;
            ok = (d <= atol) && (d >= -atol);
            total++;
            assert (ok === 1'b1) else begin
                bad++;
                $error("FAIL %s_ang observed=%0d expected=%0d+-%0d (mod 65536)", tag,
                       ang_out, ta, atol);
            end
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_ready"}, 32'(in_ready), 1);
    endtask

    // Full transaction with out_ready held high: latency, result, release.
    task automatic run_vec(input string tag, input int vx, input int vy, input int atol);
        int n;
        out_ready = 1'b1;
        wait_ready(tag);
        in_valid = 1'b1;
        x_in     = 16'(vx);
        y_in     = 16'(vy);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x_in     = 16'($urandom);
        y_in     = 16'($urandom);
        n = 0;
        while (out_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_latency"}, n, ITERS + 1);
        check_result(tag, vx, vy, atol);
        @(negedge clk);
        check_eq({tag, "_ov_drop"}, 32'(out_valid), 0);
        check_eq({tag, "_rdy_back"}, 32'(in_ready), 1);
    endtask

    initial begin
        int n;
        int vx;
        int vy;
        int seen;
        logic [15:0]        m0;
        logic signed [15:0] a0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = '0;
        y_in      = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 1);
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_mag", 32'(mag_out), 0);
        check_eq("rst_ang", 32'(ang_out), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        run_vec("pos_x", 10000, 0, 3);
        run_vec("pos_y", 0, 10000, 3);
        run_vec("q3_diag", -10000, -10000, 3);
        run_vec("neg_full", -32768, 0, 3);
        run_vec("zero", 0, 0, 3);
        run_vec("max_diag", 32767, 32767, 3);
        check_eq("max_diag_nosat", 32'(mag_out == 16'hFFFF), 0);
        run_vec("q2", -20000, 7000, 3);
        run_vec("q4", 5000, -25000, 3);

        // Random vectors of non-trivial magnitude; several table rounding
        // errors may line up, so one extra LSB of angle slack is allowed.
        for (int i = 0; i < 12; i++) begin
            vx = int'($urandom_range(65535)) - 32768;
            vy = int'($urandom_range(65535)) - 32768;
            for (int t = 0; t < 20 && (vx * vx + vy * vy) < 4096 * 4096; t++) begin
                vx = int'($urandom_range(65535)) - 32768;
                vy = int'($urandom_range(65535)) - 32768;
            end
            run_vec($sformatf("rnd%0d", i), vx, vy, 4);
        end

        // Backpressure: result held, busy-time in_valid ignored
        out_ready = 1'b0;
        wait_ready("bp");
        in_valid = 1'b1;
        x_in     = 16'sd12000;
        y_in     = 16'sd5000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        x_in     = -16'sd7000;
        y_in     = 16'sd2000;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_valid", 32'(out_valid), 1);
        check_result("bp", 12000, 5000, 3);
        m0 = mag_out;
        a0 = ang_out;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                in_valid = 1'b1;
                x_in     = 16'sd100;
                y_in     = 16'sd100;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check_eq("bp_hold_ov", 32'(out_valid), 1);
            check_eq("bp_hold_rdy", 32'(in_ready), 0);
            check_eq("bp_hold_mag", 32'(mag_out), 32'(m0));
            check_eq("bp_hold_ang", 32'(ang_out), 32'(a0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_ov", 32'(out_valid), 0);
        check_eq("bp_release_rdy", 32'(in_ready), 1);
        out_ready = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        check_eq("bp_dropped", seen, 0);
        out_ready = 1'b1;

        // Reset during iteration 5 aborts the transaction
        wait_ready("rst_mid");
        in_valid = 1'b1;
        x_in     = 16'sd20000;
        y_in     = -16'sd3000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check_eq("rst_mid_busy", 32'(in_ready), 0);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_ov", 32'(out_valid), 0);
        check_eq("rst_mid_mag", 32'(mag_out), 0);
        check_eq("rst_mid_ang", 32'(ang_out), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_rel_rdy", 32'(in_ready), 1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        check_eq("rst_aborted", seen, 0);
        run_vec("post_rst", 3000, -4000, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
